multiply32: RTL and testbench
=============================

# multiply32

Sequential 32×32 unsigned shift-add multiplier producing a 64-bit product, one partial-product add per clock. It is the direct consumer of `adder32`: every iteration routes the running high half and the selected multiplicand through one `adder32` instance and captures `result`/`cout`. It sits between the operand source (register file or bench) and the result writeback.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. Fixed to 32 because it must match `adder32`.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `mult_begin` in 1: start request. Sampled only in IDLE.
- `mult_op1` in 32: multiplicand, unsigned. Captured on acceptance.
- `mult_op2` in 32: multiplier, unsigned. Captured on acceptance.
- `busy` out 1: high while in BUSY.
- `mult_end` out 1: one-cycle completion pulse, high while in DONE.
- `product` out 64: last completed product. Held until the next completion.

## Operation

- States:
  - IDLE: waits for `mult_begin`.
  - BUSY: performs 32 iterations.
  - DONE: one cycle.
- State transitions:
  - IDLE→BUSY when `mult_begin`=1.
  - BUSY→DONE after iteration 31.
  - DONE→IDLE unconditionally.
- Internal registers:
  - `mcand[31:0]`
  - `acc_hi[31:0]`
  - `acc_lo[31:0]` (holds the multiplier, then the product low half)
  - `cnt[4:0]`
- On acceptance: `mcand`←`mult_op1`, `acc_lo`←`mult_op2`, `acc_hi`←0, `cnt`←0.
- Each BUSY cycle, `adder32` is driven with:
  - `operand1`=`acc_hi`
  - `operand2`= `acc_lo[0]` ? `mcand` : 0
  - `cin`=0
- Each BUSY edge: `{acc_hi, acc_lo}` ← `{cout, result, acc_lo[31:1]}`, and `cnt`←`cnt`+1. Keeping `cout` is what preserves the 33-bit sum; no bits are lost.
- On the edge where `cnt`=31: `product` is loaded with the shifted value, and the state moves to DONE.
- `mult_begin` is ignored in BUSY and DONE. Operand changes after acceptance have no effect.
- `mult_begin` held high continuously gives back-to-back operations. A new op is accepted on the edge leaving IDLE, so the period is 34 cycles.
- Unsigned only. There is no overflow: the 64-bit product is always exact.

## Timing

- Let E0 be the edge that samples `mult_begin`=1 in IDLE.
  - E1 through E32 perform the 32 iterations.
  - `busy`=1 from E0 until E32.
  - At E32, `product` is updated and `mult_end`=1 for exactly one cycle.
  - At E33, `mult_end`=0 and the state returns to IDLE.
  - The earliest next acceptance is E34. It can be E33 only if `mult_begin` is sampled in IDLE.
- Latency from acceptance edge to `mult_end` high is 32 cycles.
- Reset values: state IDLE, `busy`=0, `mult_end`=0, `product`=0, all internal registers 0.
- Reset asserted mid-operation:
  - Immediate asynchronous return to IDLE.
  - No `mult_end` pulse.
  - `product` clears to 0.
  - The partial result is discarded.
- `product` never shows intermediate values. It changes only at the DONE entry edge, or on reset.

## Structure

- Shared package/header `mul_defs` holds:
  - `WIDTH`=32
  - `ITER`=32
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
- One sub-module: `adder32`, instantiated once and used unmodified. There is no second adder and no `*` operator.
- The FSM, counter and datapath registers live in `multiply32` itself.

## Test plan

- 3 × 5 → `mult_end` pulses 32 cycles after acceptance, with `product`=64'h0000_0000_0000_000F.
- 32'hFFFF_FFFF × 32'hFFFF_FFFF → `product`=64'hFFFF_FFFE_0000_0001, which exercises `cout` capture on every add.
- 0 × 32'h1234_5678 → `product`=0. Also 32'h8000_0000 × 2 → 64'h0000_0001_0000_0000.
- `mult_begin` pulsed again and operands changed at cycles 5 and 20 of BUSY → ignored. The result is from the original operands, and there is exactly one `mult_end`.
- `resetn` low at iteration 16 → `busy`, `mult_end` and `product` go to 0 immediately. After release, 7 × 9 gives 63 normally.
- 1000 random `{$random}` operand pairs with `mult_begin` held high → each `product` matches a 64-bit reference product, one `mult_end` per 34 cycles.

Source files
------------

// File: rtl/mul_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_defs (package)
//  Description : Shared constants and FSM state encoding for the sequential
//                shift-add multiplier and its adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_defs;

  // Operand width; fixed to match adder32
  localparam int WIDTH = 32;

  // Number of shift-add iterations per multiply
  localparam int ITER = 32;

  // Iteration counter width
  localparam int CNT_W = $clog2(ITER);

  // Multiplier control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  // Concatenate the adder's 33-bit sum above the shifted-down low half;
  // this is the next {acc_hi, acc_lo} for one shift-add step.
  function automatic logic [2*WIDTH-1:0] shift_step(
    input logic             carry,
    input logic [WIDTH-1:0] sum,
    input logic [WIDTH-1:0] lo
  );
    return {carry, sum, lo[WIDTH-1:1]};
  endfunction

endpackage : mul_defs
`default_nettype wire

// File: rtl/adder32.sv
`default_nettype none
// ============================================================================
//  Module      : adder32
//  Description : 32-bit unsigned adder with carry in/out. Built from eight
//                4-bit carry-lookahead groups chained group to group.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder32
  import mul_defs::*;
(
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        cin,
  output logic [31:0] result,
  output logic        cout
);

  localparam int GRP_W = 4;
  localparam int NGRP  = 32 / GRP_W;

  // Carry into each group; index NGRP is the final carry out
  logic [NGRP:0] w_gcarry;

  assign w_gcarry[0] = cin;
  assign cout        = w_gcarry[NGRP];

  for (genvar g = 0; g < NGRP; g++) begin : g_group
    logic [GRP_W-1:0] w_p;
    logic [GRP_W-1:0] w_g;
    logic [GRP_W:0]   w_c;

    assign w_p = operand1[g*GRP_W +: GRP_W] ^ operand2[g*GRP_W +: GRP_W];
    assign w_g = operand1[g*GRP_W +: GRP_W] & operand2[g*GRP_W +: GRP_W];

    // Lookahead carries inside the group, all expressed from the group carry-in
    assign w_c[0] = w_gcarry[g];
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign result[g*GRP_W +: GRP_W] = w_p ^ w_c[GRP_W-1:0];
    assign w_gcarry[g+1]            = w_c[GRP_W];
  end

endmodule : adder32
`default_nettype wire

// File: rtl/multiply32.sv
`default_nettype none
// ============================================================================
//  Module      : multiply32
//  Description : Sequential 32x32 unsigned shift-add multiplier. One partial
//                product is added per clock through a single adder32; the
//                64-bit product is published on completion and held.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiply32
  import mul_defs::*;
#(
  parameter int WIDTH = mul_defs::WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mult_begin,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  output logic               busy,
  output logic               mult_end,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(ITER - 1);

  mul_state_t       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [2*WIDTH-1:0] w_next_acc;

  // The current multiplier LSB selects whether the multiplicand is added
  assign w_addend = acc_lo[0] ? mcand : '0;

  adder32 u_adder (
    .operand1 (acc_hi),
    .operand2 (w_addend),
    .cin      (1'b0),
    .result   (w_sum),
    .cout     (w_carry)
  );

  // Carry is kept as the new MSB so the 33-bit partial sum is never truncated
  assign w_next_acc = shift_step(w_carry, w_sum, acc_lo);

  // Control FSM, iteration counter and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      mult_end <= 1'b0;
      product  <= '0;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mult_end <= 1'b0;
          if (mult_begin) begin
            mcand  <= mult_op1;
            acc_lo <= mult_op2;
            acc_hi <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          {acc_hi, acc_lo} <= w_next_acc;
          cnt              <= cnt + 1'b1;
          if (cnt == c_last_iter) begin
            // Final step: publish the fully shifted accumulator
            product  <= w_next_acc;
            busy     <= 1'b0;
            mult_end <= 1'b1;
            state    <= ST_DONE;
          end
        end

        ST_DONE: begin
          mult_end <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          busy     <= 1'b0;
          mult_end <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : multiply32
`default_nettype wire

// File: tb/tb_multiply32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiply32
//  Description : Self-checking bench for multiply32. Directed corner cases,
//                ignored restarts, mid-operation reset and a randomized
//                back-to-back run against a plain 64-bit arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiply32;

  localparam int PERIOD = 10;
  localparam int NRAND  = 1000;

  logic        clk;
  logic        resetn;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic        busy;
  logic        mult_end;
  logic [63:0] product;

  int npass;
  int ntotal;

  multiply32 dut (
    .clk        (clk),
    .resetn     (resetn),
    .mult_begin (mult_begin),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .busy       (busy),
    .mult_end   (mult_end),
    .product    (product)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Reference: exact unsigned 64-bit product
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated multiply from IDLE, checking latency, result and return to idle
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 0;
    mult_begin = 1'b1;
    mult_op1   = a;
    mult_op2   = b;
    tick();
    mult_begin = 1'b0;
    mult_op1   = ~a;
    mult_op2   = ~b;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!mult_end && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd32);
    check({tag, "_product"}, product, ref_mul(a, b));
    tick();
    check({tag, "_end_drop"}, 64'({busy, mult_end}), 64'd0);
  endtask

  initial begin
    logic [63:0] exp_q[$];
    logic [63:0] keep;
    int          nend;
    int          first_end;
    int          t;
    int          last_end;
    int          nres;

    npass      = 0;
    ntotal     = 0;
    resetn     = 1'b0;
    mult_begin = 1'b0;
    mult_op1   = '0;
    mult_op2   = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_end", 64'(mult_end), 64'd0);
    check("rst_product", product, 64'd0);
    resetn = 1'b1;
    tick();

    // Directed corner cases
    run_op("3x5", 32'd3, 32'd5);
    check("3x5_const", product, 64'h0000_0000_0000_000F);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("max_const", product, 64'hFFFF_FFFE_0000_0001);
    run_op("zero", 32'd0, 32'h1234_5678);
    run_op("msb", 32'h8000_0000, 32'd2);
    check("msb_const", product, 64'h0000_0001_0000_0000);

    // Restart requests and operand changes while busy must be ignored
    mult_begin = 1'b1;
    mult_op1   = 32'hDEAD_BEEF;
    mult_op2   = 32'h0123_4567;
    tick();
    mult_begin = 1'b0;
    nend       = 0;
    first_end  = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (mult_end) begin
        nend++;
        if (first_end == 0) begin
          first_end = k;
          keep      = product;
        end
      end
      if (k == 5 || k == 20) begin
        mult_begin = 1'b1;
        mult_op1   = $urandom;
        mult_op2   = $urandom;
      end else begin
        mult_begin = 1'b0;
      end
    end
    check("ign_count", 64'(nend), 64'd1);
    check("ign_latency", 64'(first_end), 64'd32);
    check("ign_product", keep, ref_mul(32'hDEAD_BEEF, 32'h0123_4567));

    // Asynchronous reset in the middle of an operation
    mult_begin = 1'b1;
    mult_op1   = 32'hFFFF_FFFF;
    mult_op2   = 32'd3;
    tick();
    mult_begin = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_end", 64'(mult_end), 64'd0);
    check("mid_rst_product", product, 64'd0);
    tick();
    resetn = 1'b1;
    nend = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (mult_end) nend++;
    end
    check("mid_rst_no_end", 64'(nend), 64'd0);
    run_op("7x9", 32'd7, 32'd9);
    check("7x9_const", product, 64'd63);

    // Back-to-back random operations with mult_begin held high; operands
    // change every cycle, so only the values present at each acceptance
    // (every 34th edge) may appear in the results.
    mult_begin = 1'b1;
    mult_op1   = $urandom;
    mult_op2   = $urandom;
    t          = 0;
    last_end   = -1;
    nres       = 0;
    while (nres < NRAND && t < NRAND * 34 + 200) begin
      if (t % 34 == 0) exp_q.push_back(ref_mul(mult_op1, mult_op2));
      tick();
      t++;
      if (mult_end) begin
        if (exp_q.size() > 0) check("rand_product", product, exp_q.pop_front());
        else check("rand_unexpected_end", 64'(nres), 64'(NRAND));
        if (last_end >= 0) check("rand_period", 64'(t - last_end), 64'd34);
        last_end = t;
        nres++;
      end
      mult_op1 = $urandom;
      mult_op2 = $urandom;
    end
    mult_begin = 1'b0;
    check("rand_count", 64'(nres), 64'(NRAND));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule : tb_multiply32
`default_nettype wire
